// File: rtl/chip8_pkg.sv
// Shared constants and FSM state encoding for the CHIP-8 display engine.
package chip8_pkg;
  localparam int DISP_W = 64;
  localparam int DISP_H = 32;
  localparam int ADDR_W = 12;
  localparam int XW     = $clog2(DISP_W);
  localparam int YW     = $clog2(DISP_H);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, APPLY, DONE} state_t;
endpackage

// File: rtl/chip8_sprite_row_xor.sv
// XORs one sprite byte into a framebuffer row, clipping columns past the right edge.
module chip8_sprite_row_xor
  import chip8_pkg::*;
(
  input  logic [XW-1:0]     x0,
  input  logic [7:0]        sprite,
  input  logic [DISP_W-1:0] row_in,
  output logic [DISP_W-1:0] row_out,
  output logic              coll
);

  logic [XW:0] col;

  always_comb begin
    row_out = row_in;
    coll    = 1'b0;
    col     = '0;
    for (int b = 0; b < 8; b++) begin
      col = {1'b0, x0} + (XW+1)'(b);
      // MSB of the sprite byte is the leftmost pixel; no horizontal wrap.
      if (!col[XW] && sprite[7-b]) begin
        coll                 = coll | row_in[col[XW-1:0]];
        row_out[col[XW-1:0]] = ~row_in[col[XW-1:0]];
      end
    end
  end

endmodule

// File: rtl/chip8_display_engine.sv
// CHIP-8 framebuffer owner: executes CLS and DRW, exposes the pixel array to the colour mapper.
module chip8_display_engine
  import chip8_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cls_req,
  input  logic              draw_req,
  input  logic [7:0]        draw_x,
  input  logic [7:0]        draw_y,
  input  logic [3:0]        draw_n,
  input  logic [ADDR_W-1:0] draw_i,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              display [DISP_W-1:0][DISP_H-1:0]
);

  state_t              state, state_nxt;
  logic [YW-1:0]       row;
  logic [XW-1:0]       x0;
  logic [YW-1:0]       y0;
  logic [3:0]          n;
  logic [ADDR_W-1:0]   base;
  logic [YW-1:0]       yr;
  logic [YW:0]         ysum;
  logic [DISP_W-1:0]   row_vec, new_row;
  logic                row_coll;

  // row doubles as the clear-row counter and the sprite-row index r
  assign yr   = y0 + row;
  assign ysum = {1'b0, y0} + (YW+1)'(row[3:0]);

  always_comb begin
    row_vec = '0;
    for (int c = 0; c < DISP_W; c++) row_vec[c] = display[c][yr];
  end

  chip8_sprite_row_xor u_row_xor (
    .x0      (x0),
    .sprite  (mem_rdata),
    .row_in  (row_vec),
    .row_out (new_row),
    .coll    (row_coll)
  );

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cls_req)       state_nxt = CLEAR;
        else if (draw_req) state_nxt = (draw_n == 4'd0) ? DONE : FETCH;
      end
      CLEAR: begin
        busy = 1'b1;
        if (row == YW'(DISP_H-1)) state_nxt = DONE;
      end
      FETCH: begin
        busy = 1'b1;
        if (ysum >= (YW+1)'(DISP_H)) begin
          state_nxt = DONE;
        end else begin
          mem_rd    = 1'b1;
          mem_addr  = base + ADDR_W'(row[3:0]);
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        busy      = 1'b1;
        state_nxt = (row + YW'(1) == YW'(n)) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      row       <= '0;
      collision <= 1'b0;
      for (int c = 0; c < DISP_W; c++)
        for (int r = 0; r < DISP_H; r++) display[c][r] <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cls_req) begin
            row <= '0;
          end else if (draw_req) begin
            row       <= '0;
            collision <= 1'b0;
          end
        end
        CLEAR: begin
          for (int c = 0; c < DISP_W; c++) display[c][row] <= 1'b0;
          row <= row + YW'(1);
        end
        APPLY: begin
          for (int c = 0; c < DISP_W; c++) display[c][yr] <= new_row[c];
          collision <= collision | row_coll;
          row       <= row + YW'(1);
        end
        default: ;
      endcase
    end
  end

  // Draw operands are plain data; they are only meaningful after an accepted draw.
  always_ff @(posedge Clk) begin
    if (state == IDLE && !cls_req && draw_req) begin
      x0   <= draw_x[XW-1:0];
      y0   <= draw_y[YW-1:0];
      n    <= draw_n;
      base <= draw_i;
    end
  end

endmodule

// File: tb/tb_chip8_display_engine.sv
// Self-checking bench for chip8_display_engine against a pixel-level framebuffer model.
module tb_chip8_display_engine;
  import chip8_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              cls_req, draw_req;
  logic [7:0]        draw_x, draw_y;
  logic [3:0]        draw_n;
  logic [ADDR_W-1:0] draw_i;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy, done, collision;
  logic              disp [DISP_W-1:0][DISP_H-1:0];

  chip8_display_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .cls_req(cls_req), .draw_req(draw_req),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .draw_i(draw_i),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .collision(collision), .display(disp)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [4096];
  always @(posedge Clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  bit fb [DISP_W][DISP_H];
  bit m_coll;
  int exp_addr[$];
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fb_diff();
    int d = 0;
    for (int c = 0; c < DISP_W; c++)
      for (int r = 0; r < DISP_H; r++)
        if (disp[c][r] !== logic'(fb[c][r])) d++;
    return d;
  endfunction

  task automatic fb_zero();
    for (int c = 0; c < DISP_W; c++)
      for (int r = 0; r < DISP_H; r++) fb[c][r] = 1'b0;
  endtask

  // Reference: apply DRW rules directly to the pixel model, derive expected reads and latency.
  task automatic model_draw(input int x, input int y, input int n, input int i, output int lat);
    int x0, y0, k, clip, col;
    logic [7:0] b;
    x0 = x % DISP_W; y0 = y % DISP_H; k = 0; clip = 0;
    m_coll = 1'b0;
    exp_addr.delete();
    for (int r = 0; r < n; r++) begin
      if (y0 + r >= DISP_H) begin clip = 1; break; end
      exp_addr.push_back((i + r) % 4096);
      b = mem[(i + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        col = x0 + c;
        if (col < DISP_W && b[7-c]) begin
          if (fb[col][y0+r]) m_coll = 1'b1;
          fb[col][y0+r] = ~fb[col][y0+r];
        end
      end
      k++;
    end
    lat = 2*k + 1 + clip;
  endtask

  task automatic do_draw(input string tag, input int x, input int y, input int n, input int i);
    int lat, cyc;
    int got[$];
    bit seen;
    model_draw(x, y, n, i, lat);
    @(negedge Clk);
    draw_x = 8'(x); draw_y = 8'(y); draw_n = 4'(n); draw_i = ADDR_W'(i); draw_req = 1'b1;
    @(posedge Clk);
    #1 draw_req = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (mem_rd) got.push_back(int'(mem_addr));
      if (done) seen = 1;
    end
    check_eq({tag, "_latency"}, cyc, lat);
    check_eq({tag, "_nreads"}, got.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < got.size(); k++)
      check_eq({tag, "_addr"}, got[k], exp_addr[k]);
    check_eq({tag, "_collision"}, collision, m_coll);
    check_eq({tag, "_fb_diff"}, fb_diff(), 0);
  endtask

  task automatic do_clear(input string tag, input bit with_draw, input bit poke);
    int cyc, nb, nrd;
    bit seen;
    @(negedge Clk);
    cls_req = 1'b1; draw_req = with_draw;
    draw_x = 8'd1; draw_y = 8'd1; draw_n = 4'd3; draw_i = 12'h050;
    @(posedge Clk);
    #1 cls_req = 1'b0; draw_req = 1'b0;
    cyc = 0; nb = 0; nrd = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (busy) nb++;
      if (mem_rd) nrd++;
      if (done) seen = 1;
      draw_req = poke && (cyc == 5);
    end
    draw_req = 1'b0;
    fb_zero();
    check_eq({tag, "_latency"}, cyc, 33);
    check_eq({tag, "_busy_cycles"}, nb, 32);
    check_eq({tag, "_nreads"}, nrd, 0);
    check_eq({tag, "_collision"}, collision, m_coll);
    check_eq({tag, "_fb_diff"}, fb_diff(), 0);
    @(negedge Clk);
    check_eq({tag, "_idle_after"}, {busy, mem_rd, done}, 3'b000);
  endtask

  initial begin
    int ndone, nbusy;
    Reset_n = 1'b0; cls_req = 1'b0; draw_req = 1'b0;
    draw_x = '0; draw_y = '0; draw_n = '0; draw_i = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    for (int a = 12'h200; a < 12'h204; a++) mem[a] = 8'hFF;
    mem[12'h300] = 8'h80;
    fb_zero(); m_coll = 1'b0;

    repeat (2) @(negedge Clk);
    check_eq("rst_fb_diff", fb_diff(), 0);
    check_eq("rst_outputs", {busy, done, collision, mem_rd}, 4'b0000);
    check_eq("rst_mem_addr", mem_addr, 0);
    Reset_n = 1'b1;

    // Abort a draw partway through with an asynchronous reset.
    @(negedge Clk);
    draw_x = 8'd10; draw_y = 8'd3; draw_n = 4'd15; draw_i = 12'h100; draw_req = 1'b1;
    @(posedge Clk);
    #1 draw_req = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    fb_zero(); m_coll = 1'b0;
    check_eq("midrst_fb_diff", fb_diff(), 0);
    check_eq("midrst_outputs", {busy, done, collision, mem_rd}, 4'b0000);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0; nbusy = 0;
    repeat (20) begin
      @(negedge Clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check_eq("midrst_no_done", ndone, 0);
    check_eq("midrst_no_busy", nbusy, 0);

    do_draw("glyph0", 0, 0, 5, 12'h050);
    check_eq("glyph0_px", {disp[0][0], disp[3][0], disp[0][1], disp[3][1], disp[1][1], disp[3][4]}, 6'b111101);
    do_draw("glyph0_again", 0, 0, 5, 12'h050);
    check_eq("erase_coll", collision, 1'b1);
    check_eq("erase_px", {disp[0][0], disp[3][4]}, 2'b00);

    do_draw("corner", 62, 30, 4, 12'h200);
    check_eq("corner_px", {disp[62][30], disp[63][31], disp[61][30]}, 3'b110);
    do_draw("xwrap", 70, 0, 1, 12'h300);
    check_eq("xwrap_px", disp[6][0], 1'b1);
    do_draw("corner_again", 62, 30, 4, 12'h200);

    do_clear("cls", 1'b0, 1'b0);
    do_draw("setpx", 20, 10, 3, 12'h051);
    do_clear("cls_and_draw", 1'b1, 1'b0);
    do_draw("setpx2", 60, 31, 2, 12'h053);
    do_clear("cls_poke", 1'b0, 1'b1);
    do_draw("n_zero", 5, 5, 0, 12'h050);
    do_draw("addr_wrap", 5, 2, 4, 12'hFFE);

    for (int t = 0; t < 30; t++) begin
      if (t % 10 == 9) do_clear("rnd_cls", 1'b0, 1'b0);
      else do_draw("rnd", int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(15)), int'($urandom_range(4095)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
